// File: rtl/cache_fill_fsm.sv
// Purpose: cache miss handler; streams one block from memory into the data/tag arrays and
//          forwards write-through stores to memory while idle.
// Latency: reads issue from the cycle after the miss is latched; done pulses with the last returned word.
// Backpressure: none toward memory; misses and stores are level requests that the requester holds
//               until they are serviced (miss -> fill starts, store -> store_ack).
// Ports: clk/rst; miss_detected/miss_address (miss request); store_req/store_addr/store_data/store_ack
//        (write-through); mem_* (memory4c interface); write_data_array/fill_word_offset/fill_data,
//        write_tag_array/fill_block_addr (cache array writes); fsm_busy, done (status).
module cache_fill_fsm #(
    parameter int DWIDTH          = 16,
    parameter int AWIDTH          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    localparam int OFFW           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [AWIDTH-1:0] miss_address,
    input  logic              store_req,
    input  logic [AWIDTH-1:0] store_addr,
    input  logic [DWIDTH-1:0] store_data,
    output logic              store_ack,
    output logic              fsm_busy,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data_in,
    input  logic              mem_data_valid,
    input  logic [DWIDTH-1:0] mem_data_out,
    output logic              write_data_array,
    output logic [OFFW-1:0]   fill_word_offset,
    output logic [DWIDTH-1:0] fill_data,
    output logic              write_tag_array,
    output logic [AWIDTH-1:0] fill_block_addr,
    output logic              done
);

    // Counters carry one extra bit so "all words issued" is representable.
    localparam int CW = OFFW + 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     issue_cnt, issue_nx;
    logic [CW-1:0]     recv_cnt, recv_nx;
    logic [AWIDTH-1:0] base, base_nx;

    // Byte-select and in-block offset bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{store_addr[0], miss_address[OFFW:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base      <= '0;
        end else begin
            state     <= state_nx;
            issue_cnt <= issue_nx;
            recv_cnt  <= recv_nx;
            base      <= base_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        issue_nx         = issue_cnt;
        recv_nx          = recv_cnt;
        base_nx          = base;
        store_ack        = 1'b0;
        fsm_busy         = 1'b0;
        mem_enable       = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = '0;
        mem_data_in      = '0;
        write_data_array = 1'b0;
        fill_word_offset = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;
        fill_block_addr  = '0;
        done             = 1'b0;

        // Outputs are forced quiet while reset is held, even though they are combinational.
        if (!rst) begin
            fill_block_addr = base;
            case (state)
                IDLE: begin
                    // Store wins; a simultaneous miss is picked up next cycle since it is held.
                    if (store_req) begin
                        mem_enable  = 1'b1;
                        mem_wr      = 1'b1;
                        mem_addr    = {store_addr[AWIDTH-1:1], 1'b0};
                        mem_data_in = store_data;
                        store_ack   = 1'b1;
                    end else if (miss_detected) begin
                        base_nx  = {miss_address[AWIDTH-1:OFFW+1], {(OFFW+1){1'b0}}};
                        issue_nx = '0;
                        recv_nx  = '0;
                        state_nx = FILL;
                    end
                end
                FILL: begin
                    fsm_busy = 1'b1;
                    if (issue_cnt < CW'(WORDS_PER_BLOCK)) begin
                        mem_enable = 1'b1;
                        // Concatenation keeps the word offset inside the block: no carry into tag bits.
                        mem_addr   = {base[AWIDTH-1:OFFW+1], issue_cnt[OFFW-1:0], 1'b0};
                        issue_nx   = issue_cnt + 1'b1;
                    end
                    if (mem_data_valid) begin
                        write_data_array = 1'b1;
                        fill_word_offset = recv_cnt[OFFW-1:0];
                        fill_data        = mem_data_out;
                        recv_nx          = recv_cnt + 1'b1;
                        if (recv_cnt == CW'(WORDS_PER_BLOCK - 1)) begin
                            write_tag_array = 1'b1;
                            done            = 1'b1;
                            state_nx        = IDLE;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: 4-cycle pipelined memory model, transaction-level expected-output
// model checked every cycle, and directed scenarios with literal expectations.
module tb_cache_fill_fsm;
    localparam int DW = 16, AW = 16, WPB = 8, OFFW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic          store_req;
    logic [AW-1:0] store_addr;
    logic [DW-1:0] store_data;
    logic          store_ack, fsm_busy, mem_enable, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic          mem_data_valid;
    logic [DW-1:0] mem_data_out;
    logic          write_data_array;
    logic [OFFW-1:0] fill_word_offset;
    logic [DW-1:0] fill_data;
    logic          write_tag_array;
    logic [AW-1:0] fill_block_addr;
    logic          done;

    always #5 clk = ~clk;

    cache_fill_fsm #(.DWIDTH(DW), .AWIDTH(AW), .WORDS_PER_BLOCK(WPB)) dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
        .store_ack(store_ack), .fsm_busy(fsm_busy),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_valid(mem_data_valid), .mem_data_out(mem_data_out),
        .write_data_array(write_data_array), .fill_word_offset(fill_word_offset),
        .fill_data(fill_data), .write_tag_array(write_tag_array),
        .fill_block_addr(fill_block_addr), .done(done)
    );

    // ---------------- memory model (word-addressed, 4-cycle read latency) ----------------
    logic [15:0] mem   [0:32767];
    bit          wrote [0:32767];
    logic [3:0]  pv = 4'b0;
    logic [15:0] pd [4];

    // Initial image: the block at 0x1230 holds A000+i, everything else idx^5A5A.
    function automatic logic [15:0] init_word(input logic [14:0] idx);
        if (idx >= 15'h918 && idx <= 15'h91F) return 16'hA000 + 16'(idx - 15'h918);
        return {1'b0, idx} ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] rd(input logic [14:0] idx);
        return wrote[idx] ? mem[idx] : init_word(idx);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pv <= 4'b0;
        end else begin
            pv    <= {pv[2:0], mem_enable & ~mem_wr};
            pd[0] <= rd(mem_addr[15:1]);
            pd[1] <= pd[0];
            pd[2] <= pd[1];
            pd[3] <= pd[2];
            if (mem_enable && mem_wr) begin
                mem[mem_addr[15:1]]   <= mem_data_in;
                wrote[mem_addr[15:1]] <= 1'b1;
            end
        end
    end
    assign mem_data_valid = pv[3];
    assign mem_data_out   = pd[3];

    // ---------------- bookkeeping ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Observed-event statistics for the directed checks.
    int rd_cnt, first_rd_cyc, last_rd_cyc, wr_cnt, first_wr_cyc, done_cnt, done_cyc, tag_cnt;
    int ack_cnt, ack_cyc, memwr_cnt;
    logic [15:0] first_rd_addr, last_rd_addr, last_fill_data;
    int last_off;

    task automatic clear_stats();
        rd_cnt = 0; first_rd_cyc = -1; last_rd_cyc = -1; wr_cnt = 0; first_wr_cyc = -1;
        done_cnt = 0; done_cyc = -1; tag_cnt = 0; ack_cnt = 0; ack_cyc = -1; memwr_cnt = 0;
        first_rd_addr = 16'h0; last_rd_addr = 16'h0; last_fill_data = 16'h0; last_off = -1;
    endtask

    // ---------------- expected-output model + per-cycle compare ----------------
    // A fill is a 12-cycle transaction: k=1..8 issue word k-1, k=5..12 receive word k-5, k=12 finishes.
    bit          m_busy = 1'b0;
    int          m_start = 0;
    logic [15:0] m_base = 16'h0;

    always @(negedge clk) begin
        logic        e_ack, e_busy, e_en, e_wr, e_wda, e_tag, e_done;
        logic [15:0] e_addr, e_din, e_fdat, e_fba;
        int          e_off, k;
        e_ack = 0; e_busy = 0; e_en = 0; e_wr = 0; e_wda = 0; e_tag = 0; e_done = 0;
        e_addr = 0; e_din = 0; e_fdat = 0; e_off = 0;
        e_fba = rst ? 16'h0 : m_base;
        k = cyc - m_start + 1;
        if (!rst) begin
            if (!m_busy) begin
                if (store_req) begin
                    e_en = 1; e_wr = 1; e_ack = 1;
                    e_addr = store_addr & 16'hFFFE;
                    e_din = store_data;
                end
            end else begin
                e_busy = 1;
                if (k <= WPB) begin
                    e_en = 1;
                    e_addr = m_base + 16'(2 * (k - 1));
                end
                if (k >= 5) begin
                    e_wda = 1;
                    e_off = k - 5;
                    e_fdat = rd(15'((m_base + 16'(2 * (k - 5))) >> 1));
                    if (k == 12) begin e_tag = 1; e_done = 1; end
                end
            end
        end
        chk("store_ack", 32'(store_ack), 32'(e_ack));
        chk("fsm_busy", 32'(fsm_busy), 32'(e_busy));
        chk("mem_enable", 32'(mem_enable), 32'(e_en));
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_data_in", 32'(mem_data_in), 32'(e_din));
        chk("write_data_array", 32'(write_data_array), 32'(e_wda));
        chk("fill_word_offset", 32'(fill_word_offset), 32'(e_off));
        chk("fill_data", 32'(fill_data), 32'(e_fdat));
        chk("write_tag_array", 32'(write_tag_array), 32'(e_tag));
        chk("fill_block_addr", 32'(fill_block_addr), 32'(e_fba));
        chk("done", 32'(done), 32'(e_done));

        // statistics from what the DUT actually drove
        if (mem_enable && !mem_wr) begin
            if (rd_cnt == 0) begin first_rd_cyc = cyc; first_rd_addr = mem_addr; end
            rd_cnt++; last_rd_cyc = cyc; last_rd_addr = mem_addr;
        end
        if (mem_enable && mem_wr) memwr_cnt++;
        if (write_data_array) begin
            if (wr_cnt == 0) first_wr_cyc = cyc;
            wr_cnt++; last_off = int'(fill_word_offset); last_fill_data = fill_data;
        end
        if (write_tag_array) tag_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (store_ack) begin if (ack_cnt == 0) ack_cyc = cyc; ack_cnt++; end

        // advance the model to the next cycle
        if (rst) begin
            m_busy = 0; m_base = 16'h0;
        end else if (m_busy) begin
            if (k == 12) m_busy = 0;
        end else if (!store_req && miss_detected) begin
            m_busy = 1; m_start = cyc + 1; m_base = {miss_address[15:4], 4'h0};
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cnt == 0; i++) step(1);
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic start_miss(input logic [15:0] a, output int c0);
        miss_address = a; miss_detected = 1; c0 = cyc;
        step(1);
        miss_detected = 0;
    endtask

    initial begin
        int c0;
        rst = 1; miss_detected = 0; miss_address = 0; store_req = 0; store_addr = 0; store_data = 0;
        clear_stats();

        // 1: reset held two cycles, then idle with no requests
        step(1);
        chk("rst_busy", 32'(fsm_busy), 32'd0);
        step(1);
        chk("rst_outs", 32'({store_ack, mem_enable, mem_wr, write_data_array, done}), 32'd0);
        rst = 0;
        step(3);
        chk("idle_outs", 32'({fsm_busy, mem_enable, write_tag_array, fill_block_addr}), 32'd0);

        // 2: basic fill of block 0x1230
        clear_stats();
        start_miss(16'h1236, c0);
        wait_done(20);
        step(1);
        chk("t2_first_rd_cyc", 32'(first_rd_cyc - c0), 32'd1);
        chk("t2_last_rd_cyc", 32'(last_rd_cyc - c0), 32'd8);
        chk("t2_rd_cnt", 32'(rd_cnt), 32'd8);
        chk("t2_first_rd_addr", 32'(first_rd_addr), 32'h1230);
        chk("t2_last_rd_addr", 32'(last_rd_addr), 32'h123E);
        chk("t2_first_wr_cyc", 32'(first_wr_cyc - c0), 32'd5);
        chk("t2_wr_cnt", 32'(wr_cnt), 32'd8);
        chk("t2_last_off", 32'(last_off), 32'd7);
        chk("t2_last_data", 32'(last_fill_data), 32'hA007);
        chk("t2_done_cyc", 32'(done_cyc - c0), 32'd12);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        chk("t2_tag_cnt", 32'(tag_cnt), 32'd1);
        chk("t2_block_addr", 32'(fill_block_addr), 32'h1230);

        // 3: store and miss in the same idle cycle
        clear_stats();
        store_addr = 16'h0040; store_data = 16'hBEEF; store_req = 1;
        miss_address = 16'h2000; miss_detected = 1; c0 = cyc;
        step(1);
        store_req = 0;
        step(1);
        miss_detected = 0;
        wait_done(20);
        step(1);
        chk("t3_ack_cyc", 32'(ack_cyc - c0), 32'd0);
        chk("t3_memwr_cnt", 32'(memwr_cnt), 32'd1);
        chk("t3_mem_0040", 32'(rd(15'h0020)), 32'hBEEF);
        chk("t3_first_rd_cyc", 32'(first_rd_cyc - c0), 32'd2);
        chk("t3_first_rd_addr", 32'(first_rd_addr), 32'h2000);
        chk("t3_done_cyc", 32'(done_cyc - c0), 32'd13);

        // 4: store raised mid-fill (odd address) waits for idle
        clear_stats();
        start_miss(16'h0300, c0);
        step(2);
        store_addr = 16'h0051; store_data = 16'h1234; store_req = 1;
        for (int i = 0; i < 30 && ack_cnt == 0; i++) step(1);
        store_req = 0;
        chk("t4_ack_seen", 32'(ack_cnt != 0), 32'd1);
        chk("t4_ack_cyc", 32'(ack_cyc - c0), 32'd13);
        chk("t4_memwr_cnt", 32'(memwr_cnt), 32'd1);
        chk("t4_done_cyc", 32'(done_cyc - c0), 32'd12);
        step(1);
        chk("t4_mem_0050", 32'(rd(15'h0028)), 32'h1234);

        // 5: reset in fill cycle 7, then a clean fill
        clear_stats();
        start_miss(16'h0500, c0);
        step(6);
        rst = 1;
        clear_stats();
        step(1);
        rst = 0;
        step(15);
        chk("t5_no_wr", 32'(wr_cnt), 32'd0);
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        chk("t5_no_tag", 32'(tag_cnt), 32'd0);
        chk("t5_no_rd", 32'(rd_cnt), 32'd0);
        clear_stats();
        start_miss(16'h0100, c0);
        wait_done(20);
        step(1);
        chk("t5_done_cyc", 32'(done_cyc - c0), 32'd12);
        chk("t5_wr_cnt", 32'(wr_cnt), 32'd8);
        chk("t5_first_rd_addr", 32'(first_rd_addr), 32'h0100);

        // 6: top-of-memory block, no wrap
        clear_stats();
        start_miss(16'hFFFE, c0);
        wait_done(20);
        step(1);
        chk("t6_first_rd_addr", 32'(first_rd_addr), 32'hFFF0);
        chk("t6_last_rd_addr", 32'(last_rd_addr), 32'hFFFE);
        chk("t6_rd_cnt", 32'(rd_cnt), 32'd8);
        chk("t6_done_cyc", 32'(done_cyc - c0), 32'd12);
        chk("t6_block_addr", 32'(fill_block_addr), 32'hFFF0);
        chk("t6_last_data", 32'(last_fill_data), 32'h25A5);

        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
